// File: rtl/phase_rx_ctrl.sv
// phase_rx_ctrl: NRZ-M phase receiver that hunts a sync word and writes fixed-length frames to RAM
module phase_rx_ctrl #(
  parameter int data_width = 8,
  parameter int frame_length = 150,
  parameter int addr_width = 8,
  parameter int ref_clk_freq = 128000000,
  parameter int baudrate = 9600,
  parameter logic [data_width-1:0] sync_word = 8'hEB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_en,
  input  logic                  phase_in,
  output logic                  ram_clk,
  output logic                  ram_en,
  output logic [0:0]            ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_wr_data,
  output logic                  ram_rst,
  output logic                  sync_lock,
  output logic                  frame_done
);
  localparam int CYCLE = ref_clk_freq / baudrate;
  localparam int HALF = CYCLE / 2;
  localparam int BW = $clog2(data_width + 1);
  typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;
  state_t state;
  logic ph_m, ph_s, ph_d, last_sample;
  logic [15:0] cycle_cnt;
  logic [BW-1:0] bit_cnt;
  logic [data_width-1:0] hunt, shreg, hunt_nx, shreg_nx;
  logic edge_det, sample, bit_dec, last_addr, last_bit;
  always_comb begin
    edge_det = ph_s ^ ph_d;
    sample = (state != IDLE) && (cycle_cnt == 16'(HALF));
    bit_dec = ph_s ^ last_sample;
    hunt_nx = {hunt[data_width-2:0], bit_dec};
    shreg_nx = {shreg[data_width-2:0], bit_dec};
    last_addr = ram_addr == addr_width'(frame_length - 1);
    last_bit = bit_cnt == BW'(data_width - 1);
  end
  assign ram_clk = clk;
  assign ram_rst = 1'b0;
  assign sync_lock = state == RECV;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {ph_m, ph_s, ph_d, last_sample} <= '0;
      cycle_cnt <= '0;
      bit_cnt <= '0;
      hunt <= '0;
      shreg <= '0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wr_data <= '0;
      frame_done <= 1'b0;
    end else begin
      {ph_m, ph_s, ph_d} <= {phase_in, ph_m, ph_s};
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      frame_done <= 1'b0;
      // any phase transition marks a symbol boundary and re-centres the sample point
      cycle_cnt <= (state == IDLE || edge_det || cycle_cnt == 16'(CYCLE)) ? '0 : cycle_cnt + 16'd1;
      if (sample) last_sample <= ph_s;
      if (!rx_en) begin
        state <= IDLE;
        bit_cnt <= '0;
        shreg <= '0;
        ram_addr <= '0;
      end else case (state)
        IDLE: begin
          state <= HUNT;
          last_sample <= ph_s;
          hunt <= '0;
          bit_cnt <= '0;
        end
        HUNT: if (sample) begin
          hunt <= hunt_nx;
          if (hunt_nx == sync_word) begin
            state <= RECV;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          if (ram_we[0]) ram_addr <= last_addr ? '0 : ram_addr + 1'b1;
          if (ram_we[0] && last_addr) begin
            state <= HUNT;
            hunt <= '0;
          end
          if (sample) begin
            shreg <= shreg_nx;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            if (last_bit) begin
              ram_en <= 1'b1;
              ram_we <= 1'b1;
              ram_wr_data <= shreg_nx;
              frame_done <= last_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phase_rx_ctrl.sv
// tb_phase_rx_ctrl: NRZ-M stimulus with a write scoreboard for phase_rx_ctrl
module tb_phase_rx_ctrl;
  logic clk = 1'b0, rst = 1'b1, rx_en = 1'b0, phase_in = 1'b0;
  logic ram_clk, ram_en, ram_rst, sync_lock, frame_done;
  logic [0:0] ram_we;
  logic [7:0] ram_addr, ram_wr_data;
  typedef struct {logic [7:0] addr; logic [7:0] data; logic done;} exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0, done_cnt = 0;

  always #5 clk = ~clk;

  phase_rx_ctrl #(.data_width(8), .frame_length(4), .addr_width(8), .ref_clk_freq(16),
                  .baudrate(1), .sync_word(8'hEB)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .phase_in(phase_in), .ram_clk(ram_clk),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_rst(ram_rst), .sync_lock(sync_lock), .frame_done(frame_done));

  // scoreboard: every RAM strobe or frame_done pops one expected write
  always @(negedge clk) begin
    if (ram_we[0] || ram_en || frame_done) begin
      total++;
      if (frame_done) done_cnt++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_write en=%b we=%b addr=%0d data=%h done=%b", ram_en, ram_we, ram_addr, ram_wr_data, frame_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({ram_en, ram_we, ram_addr, ram_wr_data, frame_done} !== {2'b11, e.addr, e.data, e.done}) begin
          bad++;
          $display("FAIL write got en=%b we=%b addr=%0d data=%h done=%b exp addr=%0d data=%h done=%b",
                   ram_en, ram_we, ram_addr, ram_wr_data, frame_done, e.addr, e.data, e.done);
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int per);
    if (b) phase_in = ~phase_in;
    repeat (per) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input int per);
    for (int i = 7; i >= 0; i--) send_bit(v[i], per);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b0, 17);
  endtask

  task automatic send_frame(input logic [7:0] d0, d1, d2, d3, input int per);
    logic [7:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 8'(i), data: d[i], done: i == 3});
    send_byte(8'hEB, per);
    for (int i = 0; i < 4; i++) send_byte(d[i], per);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_en = 1'b0;
    repeat (3) @(negedge clk);
    total += 8;
    if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
    if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    if (ram_addr !== 8'd0) begin bad++; $display("FAIL reset_ram_addr got=%0d exp=0", ram_addr); end
    if (ram_wr_data !== 8'd0) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", ram_wr_data); end
    if (sync_lock !== 1'b0) begin bad++; $display("FAIL reset_sync_lock got=%b exp=0", sync_lock); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    if (ram_rst !== 1'b0) begin bad++; $display("FAIL ram_rst got=%b exp=0", ram_rst); end
    if (ram_clk !== 1'b0) begin bad++; $display("FAIL ram_clk_low got=%b exp=0", ram_clk); end
    @(posedge clk); #1;
    total++;
    if (ram_clk !== 1'b1) begin bad++; $display("FAIL ram_clk_high got=%b exp=1", ram_clk); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame;
    int d0 = done_cnt;
    rx_en = 1'b1;
    idle(4);
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 17);
    idle(3);
    total += 4;
    if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt - d0); end
    if (sync_lock !== 1'b0) begin bad++; $display("FAIL single_unlock got=%b exp=0", sync_lock); end
    if (ram_addr !== 8'd0) begin bad++; $display("FAIL single_addr_wrap got=%0d exp=0", ram_addr); end
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    send_frame(8'hA5, 8'h5A, 8'hC3, 8'h3C, 17);
    send_frame(8'h01, 8'h80, 8'h7E, 8'hEB, 17);
    idle(3);
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d exp=2", done_cnt - d0); end
  endtask

  task automatic test_no_lock;
    int d0 = done_cnt;
    repeat (3) send_byte(8'h00, 17);
    total++;
    if (sync_lock !== 1'b0) begin bad++; $display("FAIL nolock_lock got=%b exp=0", sync_lock); end
    send_frame(8'h00, 8'hFF, 8'h00, 8'hFF, 17);
    idle(3);
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL nolock_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL nolock_done_cnt got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_drift;
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 18);
    idle(3);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drift_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_rx_en_drop;
    exp_q.push_back('{addr: 8'd0, data: 8'h9C, done: 1'b0});
    send_byte(8'hEB, 17);
    send_byte(8'h9C, 17);
    send_bit(1'b0, 17);
    send_bit(1'b0, 17);
    send_bit(1'b1, 17);
    rx_en = 1'b0;
    repeat (3) @(negedge clk);
    total += 3;
    if (ram_addr !== 8'd0) begin bad++; $display("FAIL drop_addr got=%0d exp=0", ram_addr); end
    if (sync_lock !== 1'b0) begin bad++; $display("FAIL drop_lock got=%b exp=0", sync_lock); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL drop_byte1 got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    rx_en = 1'b1;
    idle(3);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 17);
    idle(3);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drop_refill got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_rst_midbyte;
    exp_q.push_back('{addr: 8'd0, data: 8'h6D, done: 1'b0});
    send_byte(8'hEB, 17);
    send_byte(8'h6D, 17);
    for (int i = 0; i < 4; i++) send_bit(i[0], 17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 5;
    if (ram_we !== 1'b0 || ram_en !== 1'b0) begin bad++; $display("FAIL rst_we got=%b%b exp=00", ram_en, ram_we); end
    if (ram_addr !== 8'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", ram_addr); end
    if (ram_wr_data !== 8'd0) begin bad++; $display("FAIL rst_data got=%h exp=00", ram_wr_data); end
    if (sync_lock !== 1'b0) begin bad++; $display("FAIL rst_lock got=%b exp=0", sync_lock); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL rst_byte1 got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    idle(10);
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 17);
    idle(3);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rst_resume got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_no_lock;
    test_drift;
    test_rx_en_drop;
    test_rst_midbyte;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
